debug_sequencer: RTL and testbench

//  Parametrised run-control FSM between the host debug link and the CPU top.

---
 rtl/debug_sequencer_if.sv | 35 +++
 rtl/debug_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_debug_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_sequencer_if.sv
// Command channel between the host debug link and the run-control sequencer.
// The host side (master) issues commands; the sequencer (slave) accepts them
// and reports completion with a one-cycle done pulse plus a reason code.
interface debug_sequencer_if #(
  parameter int unsigned ARG_WIDTH = 32,
  parameter int unsigned IDX_WIDTH = 3
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [ARG_WIDTH-1:0] cmd_arg;
  logic [IDX_WIDTH-1:0] cmd_idx;
  logic                 cmd_done;
  logic [2:0]           done_reason;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    output cmd_idx,
    input  cmd_ready,
    input  cmd_done,
    input  done_reason
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    input  cmd_idx,
    output cmd_ready,
    output cmd_done,
    output done_reason
  );
endinterface

// File: rtl/debug_sequencer.sv
// Run-control sequencer: takes host commands and drives the CPU halt line.
// Supports free run, step-N-instructions, step-N-cycles, abort and PC
// breakpoints; reports one done pulse with a reason per command and latches
// program exit until reset.
module debug_sequencer #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned NUM_BP    = 4,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned ARG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  debug_sequencer_if.slave     cmd,
  output logic                 cpu_halt,
  input  logic [PC_WIDTH-1:0]  cpu_pc,
  input  logic                 instr_retired,
  input  logic                 sw_bp_fired,
  input  logic                 finish_exec,
  output logic                 exit_signal,
  output logic [CNT_WIDTH-1:0] steps_left
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRun    = 3'd1;
  localparam logic [2:0] StStepi  = 3'd2;
  localparam logic [2:0] StStepc  = 3'd3;
  localparam logic [2:0] StExited = 3'd4;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpRun   = 3'd1;
  localparam logic [2:0] OpStepi = 3'd2;
  localparam logic [2:0] OpStepc = 3'd3;
  localparam logic [2:0] OpHalt  = 3'd4;
  localparam logic [2:0] OpSetBp = 3'd5;
  localparam logic [2:0] OpClrBp = 3'd6;

  localparam logic [2:0] RsnOk       = 3'd0;
  localparam logic [2:0] RsnStepDone = 3'd1;
  localparam logic [2:0] RsnHwBp     = 3'd2;
  localparam logic [2:0] RsnSwBp     = 3'd3;
  localparam logic [2:0] RsnAbort    = 3'd4;
  localparam logic [2:0] RsnExit     = 3'd5;
  localparam logic [2:0] RsnBadCmd   = 3'd6;

  logic [2:0]           state_q, state_d;
  logic                 halt_q, halt_d;
  logic                 done_q, done_d;
  logic [2:0]           reason_q, reason_d;
  logic                 exit_q, exit_d;
  logic [CNT_WIDTH-1:0] steps_q, steps_d;
  logic                 fresh_q, fresh_d;
  logic [NUM_BP-1:0]    bp_en_q, bp_en_d;
  logic [PC_WIDTH-1:0]  bp_addr_q [NUM_BP];
  logic [PC_WIDTH-1:0]  bp_addr_d [NUM_BP];

  logic                 ready;
  logic                 accept;
  logic                 idx_ok;
  logic                 bp_match;
  logic                 hw_hit;
  logic                 step_tick;
  logic                 step_last;
  logic                 stop;
  logic [2:0]           stop_reason;
  logic [CNT_WIDTH-1:0] arg_cnt;
  logic                 unused_arg;

  assign arg_cnt    = cmd.cmd_arg[CNT_WIDTH-1:0];
  assign unused_arg = ^cmd.cmd_arg;
  assign accept     = cmd.cmd_valid && ready;
  assign idx_ok     = 32'(cmd.cmd_idx) < NUM_BP;

  // Idle takes anything; a running CPU can only be interrupted by HALT.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      StIdle:                  ready = 1'b1;
      StRun, StStepi, StStepc: ready = (cmd.cmd_op == OpHalt);
      default:                 ready = 1'b0;
    endcase
  end

  // Breakpoint compare; the first running cycle is masked so a stop on a
  // breakpoint can be resumed without trapping again at the same PC.
  always_comb begin
    bp_match = 1'b0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (bp_en_q[i] && (cpu_pc == bp_addr_q[i])) bp_match = 1'b1;
    end
    hw_hit    = bp_match && !fresh_q && ((state_q == StRun) || (state_q == StStepi));
    step_tick = ((state_q == StStepi) && instr_retired) || (state_q == StStepc);
    step_last = step_tick && (steps_q == CNT_WIDTH'(1));
  end

  // Stop arbitration while running: exit, abort, sw bp, hw bp, step count.
  always_comb begin
    stop        = 1'b1;
    stop_reason = RsnOk;
    if (finish_exec)     stop_reason = RsnExit;
    else if (accept)     stop_reason = RsnAbort;
    else if (sw_bp_fired) stop_reason = RsnSwBp;
    else if (hw_hit)     stop_reason = RsnHwBp;
    else if (step_last)  stop_reason = RsnStepDone;
    else                 stop = 1'b0;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    halt_d    = halt_q;
    done_d    = 1'b0;
    reason_d  = reason_q;
    exit_d    = exit_q;
    steps_d   = steps_q;
    fresh_d   = fresh_q;
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          case (cmd.cmd_op)
            OpNop, OpHalt: begin
              done_d   = 1'b1;
              reason_d = RsnOk;
            end
            OpRun: begin
              state_d = StRun;
              halt_d  = 1'b0;
              fresh_d = 1'b1;
            end
            OpStepi, OpStepc: begin
              steps_d = arg_cnt;
              if (arg_cnt == '0) begin
                done_d   = 1'b1;
                reason_d = RsnStepDone;
              end else begin
                state_d = (cmd.cmd_op == OpStepi) ? StStepi : StStepc;
                halt_d  = 1'b0;
                fresh_d = 1'b1;
              end
            end
            OpSetBp, OpClrBp: begin
              done_d   = 1'b1;
              reason_d = idx_ok ? RsnOk : RsnBadCmd;
              for (int unsigned i = 0; i < NUM_BP; i++) begin
                if (idx_ok && (32'(cmd.cmd_idx) == i)) begin
                  bp_en_d[i] = (cmd.cmd_op == OpSetBp);
                  if (cmd.cmd_op == OpSetBp) bp_addr_d[i] = cmd.cmd_arg[PC_WIDTH-1:0];
                end
              end
            end
            default: begin
              done_d   = 1'b1;
              reason_d = RsnBadCmd;
            end
          endcase
        end
      end
      StRun, StStepi, StStepc: begin
        fresh_d = 1'b0;
        // Counter saturates at zero rather than wrapping.
        if (step_tick && (steps_q != '0)) steps_d = steps_q - CNT_WIDTH'(1);
        if (stop) begin
          done_d   = 1'b1;
          reason_d = stop_reason;
          halt_d   = 1'b1;
          if (stop_reason == RsnExit) begin
            state_d = StExited;
            exit_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      halt_q    <= 1'b1;
      done_q    <= 1'b0;
      reason_q  <= RsnOk;
      exit_q    <= 1'b0;
      steps_q   <= '0;
      fresh_q   <= 1'b0;
      bp_en_q   <= '0;
      bp_addr_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      done_q    <= done_d;
      reason_q  <= reason_d;
      exit_q    <= exit_d;
      steps_q   <= steps_d;
      fresh_q   <= fresh_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
    end
  end

  assign cmd.cmd_ready   = ready;
  assign cmd.cmd_done    = done_q;
  assign cmd.done_reason = reason_q;
  assign cpu_halt        = halt_q;
  assign exit_signal     = exit_q;
  assign steps_left      = steps_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: directed command sequences, a behavioural
// reference model compared every cycle, and literal end-of-scenario checks.
module tb_debug_sequencer;
  localparam int NBP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_pc = '0;
  logic        instr_retired = 1'b0;
  logic        sw_bp_fired = 1'b0;
  logic        finish_exec = 1'b0;
  logic        cpu_halt;
  logic        exit_signal;
  logic [15:0] steps_left;

  always #5 clk = ~clk;

  debug_sequencer_if #(.ARG_WIDTH(32), .IDX_WIDTH(3)) bus ();

  debug_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (bus),
    .cpu_halt      (cpu_halt),
    .cpu_pc        (cpu_pc),
    .instr_retired (instr_retired),
    .sw_bp_fired   (sw_bp_fired),
    .finish_exec   (finish_exec),
    .exit_signal   (exit_signal),
    .steps_left    (steps_left)
  );

  int errors = 0;
  int checks = 0;
  int halt_low = 0;
  int done_cnt = 0;
  int last_reason = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_STEPI = 2, M_STEPC = 3, M_EXIT = 4;
  int          m_mode = M_IDLE;
  bit          m_halt = 1'b1, m_done = 1'b0, m_exit = 1'b0, m_fresh = 1'b0;
  int          m_reason = 0;
  int unsigned m_steps = 0;
  bit          m_bp_en [NBP];
  int unsigned m_bp_pc [NBP];

  task automatic m_finish(input int r);
    m_done   = 1'b1;
    m_reason = r;
  endtask

  task automatic m_idle_cmd();
    int op;
    op = int'(bus.cmd_op);
    if (op == 0 || op == 4) m_finish(0);
    else if (op == 1) begin
      m_mode = M_RUN; m_halt = 1'b0; m_fresh = 1'b1;
    end else if (op == 2 || op == 3) begin
      m_steps = bus.cmd_arg[15:0];
      if (m_steps == 0) m_finish(1);
      else begin
        m_mode = (op == 2) ? M_STEPI : M_STEPC; m_halt = 1'b0; m_fresh = 1'b1;
      end
    end else if (op == 5 || op == 6) begin
      if (int'(bus.cmd_idx) >= NBP) m_finish(6);
      else begin
        m_bp_en[bus.cmd_idx[1:0]] = (op == 5);
        if (op == 5) m_bp_pc[bus.cmd_idx[1:0]] = bus.cmd_arg;
        m_finish(0);
      end
    end else m_finish(6);
  endtask

  task automatic m_running();
    bit hit, counts, last;
    int why;
    hit = 1'b0;
    if (m_mode != M_STEPC && !m_fresh)
      foreach (m_bp_en[i]) if (m_bp_en[i] && m_bp_pc[i] == cpu_pc) hit = 1'b1;
    counts = (m_mode == M_STEPI && instr_retired) || m_mode == M_STEPC;
    last   = counts && m_steps == 1;
    if (counts && m_steps > 0) m_steps--;
    why = finish_exec ? 5 : (bus.cmd_valid && bus.cmd_op == 3'd4) ? 4 :
          sw_bp_fired ? 3 : hit ? 2 : last ? 1 : -1;
    m_fresh = 1'b0;
    if (why >= 0) begin
      m_finish(why);
      m_halt = 1'b1;
      m_mode = (why == 5) ? M_EXIT : M_IDLE;
      if (why == 5) m_exit = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_halt = 1'b1; m_reason = 0; m_exit = 1'b0;
      m_steps = 0; m_fresh = 1'b0;
      foreach (m_bp_en[i]) begin m_bp_en[i] = 1'b0; m_bp_pc[i] = 0; end
    end else if (m_mode == M_IDLE) begin
      if (bus.cmd_valid) m_idle_cmd();
    end else if (m_mode != M_EXIT) begin
      m_running();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit exp_ready;
    #2;
    exp_ready = (m_mode == M_IDLE) ? 1'b1 : (m_mode == M_EXIT) ? 1'b0 : (bus.cmd_op == 3'd4);
    chk("model_halt", cpu_halt, m_halt);
    chk("model_done", bus.cmd_done, m_done);
    if (m_done) chk("model_reason", bus.done_reason, m_reason);
    chk("model_exit", exit_signal, m_exit);
    chk("model_steps", steps_left, m_steps);
    chk("model_ready", bus.cmd_ready, exp_ready);
    if (cpu_halt === 1'b0) halt_low++;
    if (bus.cmd_done === 1'b1) begin
      done_cnt++;
      last_reason = int'(bus.done_reason);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [2:0] op, input logic [31:0] arg, input logic [2:0] idx);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_arg = arg; bus.cmd_idx = idx;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #3; n++;
    end
    chk(name, done_cnt != d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_arg = '0; bus.cmd_idx = '0;
    repeat (2) @(negedge clk);
    #5;
    chk("rst_halt", cpu_halt, 1); chk("rst_done", bus.cmd_done, 0);
    chk("rst_reason", bus.done_reason, 0); chk("rst_exit", exit_signal, 0);
    chk("rst_steps", steps_left, 0); chk("rst_ready", bus.cmd_ready, 1);
    @(negedge clk); reset = 1'b0;

    // 1: STEPI 3, retire every second cycle
    halt_low = 0; d0 = done_cnt;
    send(3'd2, 32'd3, 3'd0);
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk); instr_retired = (k % 2 == 0) && (k <= 6);
    end
    instr_retired = 1'b0;
    #5;
    chk("t1_halt_low", halt_low, 6); chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_reason", last_reason, 1); chk("t1_steps", steps_left, 0);

    // 2: breakpoint at 0x10, then resume from it
    d0 = done_cnt;
    send(3'd5, 32'h10, 3'd0);
    #5; chk("t2_setbp_done", done_cnt - d0, 1); chk("t2_setbp_reason", last_reason, 0);
    cpu_pc = 32'h0; halt_low = 0; d0 = done_cnt;
    send(3'd1, 32'd0, 3'd0);
    cpu_pc = 32'h4;
    @(negedge clk); cpu_pc = 32'h8;
    @(negedge clk); cpu_pc = 32'h10;
    @(negedge clk); #5;
    chk("t2_hw_done", done_cnt - d0, 1); chk("t2_hw_reason", last_reason, 2);
    chk("t2_halt_low", halt_low, 3); chk("t2_halted", cpu_halt, 1);
    d0 = done_cnt;
    send(3'd1, 32'd0, 3'd0);
    @(negedge clk); cpu_pc = 32'h14;
    repeat (4) @(negedge clk);
    #5; chk("t2_no_retrap", done_cnt - d0, 0); chk("t2_running", cpu_halt, 0);
    send(3'd4, 32'd0, 3'd0);
    #5; chk("t2_abort_done", done_cnt - d0, 1); chk("t2_abort_reason", last_reason, 4);

    // 3: STEPC 5 and STEPC 0
    halt_low = 0;
    send(3'd3, 32'd5, 3'd0);
    wait_done(20, "t3_stepc_timeout");
    #2; chk("t3_reason", last_reason, 1); chk("t3_halt_low", halt_low, 5);
    halt_low = 0; d0 = done_cnt;
    send(3'd3, 32'd0, 3'd0);
    #5;
    chk("t3_zero_done", done_cnt - d0, 1); chk("t3_zero_reason", last_reason, 1);
    chk("t3_zero_halt_low", halt_low, 0);

    // 4: busy RUN refused; HALT with simultaneous sw bp gives one ABORT
    d0 = done_cnt;
    send(3'd1, 32'd0, 3'd0);
    repeat (2) @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1;
    #1; chk("t4_ready_busy_run", bus.cmd_ready, 0);
    @(negedge clk);
    bus.cmd_op = 3'd4; sw_bp_fired = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; sw_bp_fired = 1'b0;
    repeat (3) @(negedge clk);
    #5;
    chk("t4_single_done", done_cnt - d0, 1); chk("t4_reason", last_reason, 4);
    chk("t4_halted", cpu_halt, 1);

    // 5: exit during STEPI, then reset
    d0 = done_cnt;
    send(3'd2, 32'd10, 3'd0);
    @(negedge clk); finish_exec = 1'b1;
    @(negedge clk); finish_exec = 1'b0;
    #5;
    chk("t5_done", done_cnt - d0, 1); chk("t5_reason", last_reason, 5);
    chk("t5_exit", exit_signal, 1); chk("t5_halt", cpu_halt, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0;
    #1; chk("t5_ready", bus.cmd_ready, 0);
    repeat (3) @(negedge clk);
    #5; chk("t5_exit_sticky", exit_signal, 1); chk("t5_no_more_done", done_cnt - d0, 1);
    bus.cmd_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #5;
    chk("t5_rst_halt", cpu_halt, 1); chk("t5_rst_done", bus.cmd_done, 0);
    chk("t5_rst_reason", bus.done_reason, 0); chk("t5_rst_exit", exit_signal, 0);
    chk("t5_rst_steps", steps_left, 0); chk("t5_rst_ready", bus.cmd_ready, 1);
    @(negedge clk); reset = 1'b0;

    // 6: bad index and bad opcode, then reset mid-RUN
    d0 = done_cnt;
    send(3'd5, 32'h20, 3'd4);
    #5; chk("t6_badidx_done", done_cnt - d0, 1); chk("t6_badidx_reason", last_reason, 6);
    send(3'd7, 32'h0, 3'd0);
    #5; chk("t6_badop_reason", last_reason, 6);
    cpu_pc = 32'h20; d0 = done_cnt;
    send(3'd1, 32'd0, 3'd0);
    repeat (5) @(negedge clk);
    #5; chk("t6_bp_not_enabled", done_cnt - d0, 0); chk("t6_running", cpu_halt, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    #5; chk("t6_rst_no_done", done_cnt - d0, 0); chk("t6_rst_halt", cpu_halt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
